// File: rtl/fight_pkg.sv
// Shared encodings for the fight datapath: player FSM states, match states,
// winner codes and box geometry types.
package fight_pkg;

  localparam int unsigned COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x1;
    coord_t x2;
    coord_t y1;
    coord_t y2;
  } box_t;

  localparam logic [3:0] ST_IDLE           = 4'd0;
  localparam logic [3:0] ST_MOVEFORWARD    = 4'd1;
  localparam logic [3:0] ST_MOVEBACKWARDS  = 4'd2;
  localparam logic [3:0] ST_B_ATTACK_START = 4'd3;
  localparam logic [3:0] ST_B_ATTACK_END   = 4'd4;
  localparam logic [3:0] ST_B_ATTACK_PULL  = 4'd5;

  localparam logic M_FIGHT = 1'b0;
  localparam logic M_KO    = 1'b1;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  function automatic logic in_attack(input logic [3:0] st);
    return (st == ST_B_ATTACK_START) || (st == ST_B_ATTACK_END) || (st == ST_B_ATTACK_PULL);
  endfunction

endpackage

// File: rtl/box_overlap.sv
// Normalizes two axis-aligned boxes (bounds in either order) and reports
// whether they overlap; touching edges count as overlap.
module box_overlap
  import fight_pkg::*;
(
  input  box_t a,
  input  box_t b,
  output logic overlap
);

  coord_t a_xlo, a_xhi, a_ylo, a_yhi;
  coord_t b_xlo, b_xhi, b_ylo, b_yhi;

  always_comb begin
    a_xlo = (a.x1 < a.x2) ? a.x1 : a.x2;
    a_xhi = (a.x1 < a.x2) ? a.x2 : a.x1;
    a_ylo = (a.y1 < a.y2) ? a.y1 : a.y2;
    a_yhi = (a.y1 < a.y2) ? a.y2 : a.y1;
    b_xlo = (b.x1 < b.x2) ? b.x1 : b.x2;
    b_xhi = (b.x1 < b.x2) ? b.x2 : b.x1;
    b_ylo = (b.y1 < b.y2) ? b.y1 : b.y2;
    b_yhi = (b.y1 < b.y2) ? b.y2 : b.y1;
    overlap = (a_xlo <= b_xhi) && (b_xlo <= a_xhi) &&
              (a_ylo <= b_yhi) && (b_ylo <= a_yhi);
  end

endmodule

// File: rtl/hit_resolver.sv
// Combat arbiter: one damage event per attack, per-player hitstun counters
// and a FIGHT/KO match state machine that latches the winner.
module hit_resolver
  import fight_pkg::*;
#(
  parameter int unsigned HEALTH_W    = 4,
  parameter int unsigned MAX_HEALTH  = 10,
  parameter int unsigned DAMAGE      = 1,
  parameter int unsigned STUN_FRAMES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          p1_state,
  input  logic [3:0]          p2_state,
  input  logic [COORD_W-1:0]  p1_hit_x1,
  input  logic [COORD_W-1:0]  p1_hit_x2,
  input  logic [COORD_W-1:0]  p1_hit_y1,
  input  logic [COORD_W-1:0]  p1_hit_y2,
  input  logic [COORD_W-1:0]  p1_hurt_x1,
  input  logic [COORD_W-1:0]  p1_hurt_x2,
  input  logic [COORD_W-1:0]  p1_hurt_y1,
  input  logic [COORD_W-1:0]  p1_hurt_y2,
  input  logic [COORD_W-1:0]  p2_hit_x1,
  input  logic [COORD_W-1:0]  p2_hit_x2,
  input  logic [COORD_W-1:0]  p2_hit_y1,
  input  logic [COORD_W-1:0]  p2_hit_y2,
  input  logic [COORD_W-1:0]  p2_hurt_x1,
  input  logic [COORD_W-1:0]  p2_hurt_x2,
  input  logic [COORD_W-1:0]  p2_hurt_y1,
  input  logic [COORD_W-1:0]  p2_hurt_y2,
  output logic [HEALTH_W-1:0] p1_health,
  output logic [HEALTH_W-1:0] p2_health,
  output logic                p1_hit,
  output logic                p2_hit,
  output logic                p1_stun,
  output logic                p2_stun,
  output logic                ko,
  output logic [1:0]          winner
);

  localparam int unsigned STUN_W = $clog2(STUN_FRAMES + 1);
  localparam logic [HEALTH_W-1:0] HEALTH_INIT = HEALTH_W'(MAX_HEALTH);
  localparam logic [HEALTH_W-1:0] DMG         = HEALTH_W'(DAMAGE);
  localparam logic [STUN_W-1:0]   STUN_LOAD   = STUN_W'(STUN_FRAMES);

  box_t p1_box, p1_hurt, p2_box, p2_hurt;
  logic ov_p1_on_p2_hurt, ov_p1_on_p2_box, ov_p2_on_p1_hurt, ov_p2_on_p1_box;

  assign p1_box  = '{x1: p1_hit_x1,  x2: p1_hit_x2,  y1: p1_hit_y1,  y2: p1_hit_y2};
  assign p1_hurt = '{x1: p1_hurt_x1, x2: p1_hurt_x2, y1: p1_hurt_y1, y2: p1_hurt_y2};
  assign p2_box  = '{x1: p2_hit_x1,  x2: p2_hit_x2,  y1: p2_hit_y1,  y2: p2_hit_y2};
  assign p2_hurt = '{x1: p2_hurt_x1, x2: p2_hurt_x2, y1: p2_hurt_y1, y2: p2_hurt_y2};

  box_overlap u_ov_p1_on_p2_hurt (.a(p1_box), .b(p2_hurt), .overlap(ov_p1_on_p2_hurt));
  box_overlap u_ov_p1_on_p2_box  (.a(p1_box), .b(p2_box),  .overlap(ov_p1_on_p2_box));
  box_overlap u_ov_p2_on_p1_hurt (.a(p2_box), .b(p1_hurt), .overlap(ov_p2_on_p1_hurt));
  box_overlap u_ov_p2_on_p1_box  (.a(p2_box), .b(p1_box),  .overlap(ov_p2_on_p1_box));

  logic [HEALTH_W-1:0] p1_health_q, p1_health_d, p2_health_q, p2_health_d;
  logic [STUN_W-1:0]   p1_stun_q, p1_stun_d, p2_stun_q, p2_stun_d;
  logic                p1_hit_q, p2_hit_q;
  logic                p1_landed_q, p1_landed_d, p2_landed_q, p2_landed_d;
  logic                match_q, match_d;
  logic [1:0]          winner_q, winner_d;
  logic                cand_1, cand_2;

  // cand_N means player N takes damage this edge.
  always_comb begin
    cand_2 = (p1_state == ST_B_ATTACK_END) && !p1_landed_q && (match_q == M_FIGHT) &&
             (ov_p1_on_p2_hurt || (in_attack(p2_state) && ov_p1_on_p2_box));
    cand_1 = (p2_state == ST_B_ATTACK_END) && !p2_landed_q && (match_q == M_FIGHT) &&
             (ov_p2_on_p1_hurt || (in_attack(p1_state) && ov_p2_on_p1_box));
  end

  always_comb begin
    p1_health_d = p1_health_q;
    p2_health_d = p2_health_q;
    if (cand_1) p1_health_d = (p1_health_q >= DMG) ? p1_health_q - DMG : '0;
    if (cand_2) p2_health_d = (p2_health_q >= DMG) ? p2_health_q - DMG : '0;

    p1_stun_d = (p1_stun_q != '0) ? p1_stun_q - 1'b1 : '0;
    p2_stun_d = (p2_stun_q != '0) ? p2_stun_q - 1'b1 : '0;
    if (cand_1) p1_stun_d = STUN_LOAD;
    if (cand_2) p2_stun_d = STUN_LOAD;

    // Latch stays armed for the whole attack, not just the active frame.
    p1_landed_d = in_attack(p1_state) ? (p1_landed_q | cand_2) : 1'b0;
    p2_landed_d = in_attack(p2_state) ? (p2_landed_q | cand_1) : 1'b0;
  end

  always_comb begin
    match_d  = match_q;
    winner_d = winner_q;
    if (match_q == M_FIGHT && (p1_health_q == '0 || p2_health_q == '0)) begin
      match_d = M_KO;
      if (p1_health_q == '0 && p2_health_q == '0) winner_d = WIN_DRAW;
      else if (p2_health_q == '0)                 winner_d = WIN_P1;
      else                                        winner_d = WIN_P2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_health_q <= HEALTH_INIT;
      p2_health_q <= HEALTH_INIT;
      p1_stun_q   <= '0;
      p2_stun_q   <= '0;
      p1_hit_q    <= 1'b0;
      p2_hit_q    <= 1'b0;
      p1_landed_q <= 1'b0;
      p2_landed_q <= 1'b0;
      match_q     <= M_FIGHT;
      winner_q    <= WIN_NONE;
    end else begin
      p1_health_q <= p1_health_d;
      p2_health_q <= p2_health_d;
      p1_stun_q   <= p1_stun_d;
      p2_stun_q   <= p2_stun_d;
      p1_hit_q    <= cand_1;
      p2_hit_q    <= cand_2;
      p1_landed_q <= p1_landed_d;
      p2_landed_q <= p2_landed_d;
      match_q     <= match_d;
      winner_q    <= winner_d;
    end
  end

  assign p1_health = p1_health_q;
  assign p2_health = p2_health_q;
  assign p1_hit    = p1_hit_q;
  assign p2_hit    = p2_hit_q;
  assign p1_stun   = (p1_stun_q != '0);
  assign p2_stun   = (p2_stun_q != '0);
  assign ko        = (match_q == M_KO);
  assign winner    = winner_q;

endmodule
